mult_seq: RTL and testbench

Iterative shift-add multiply controller for the 5-stage MIPS core. Sequences MULT/MULTU over WIDTH cycles, owns the HI/LO registers (including MTHI/MTLO writes), and drives the busy stall consumed by the hazard unit's multiply-stall input. It sits beside the EX stage and takes operands from the forwarded ID/EX register values.

---
 rtl/mult_seq.sv | 141 ++++++++++++++
 tb/tb_mult_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_seq.sv
// ---------------------------------------------------------------------------
// mult_seq : iterative shift-add multiply controller and HI/LO register owner
//
// Runs MULT/MULTU for the 5-stage MIPS core, one partial-product add per
// cycle. It also owns the architectural HI/LO pair, including MTHI/MTLO
// writes. While a multiply is in flight, busy stalls the pipeline through
// the hazard unit.
//
// Ports
//   clk        core clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   start      issue a multiply (ignored unless idle)
//   signed_op  1 = MULT (two's complement), 0 = MULTU
//   flush      abort an in-flight multiply; HI/LO are left untouched
//   a, b       rs / rt operands (forwarded ID/EX values)
//   mthi/mtlo  write hi_wdata / lo_wdata (honoured only when idle, no start)
//   hi_wdata   MTHI data
//   lo_wdata   MTLO data
//   busy       multiply in flight (RUN or FIX)
//   done       one-cycle pulse in the FIX cycle
//   hi, lo     HI / LO registers
//
// Optional build macro: MULT_EARLY_TERM_EN
//   When defined, RUN ends as soon as the remaining multiplier bits are all
//   zero. When undefined, RUN always lasts exactly WIDTH cycles.
// ---------------------------------------------------------------------------
module mult_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_op,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] hi_wdata,
  input  logic [WIDTH-1:0] lo_wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic               run_last;
  logic [2*WIDTH-1:0] result;

  // Operand magnitude. The most negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit number.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                 input logic             s);
    return (s && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
  endfunction

  // Applies the sign to the unsigned magnitude product.
  function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] p,
                                                    input logic               n);
    return n ? (~p + (2*WIDTH)'(1)) : p;
  endfunction

`ifdef MULT_EARLY_TERM_EN
  // The cycle that consumes the last set multiplier bit is the final RUN
  // cycle. With b=0 this still gives one RUN cycle.
  assign run_last = (cnt == CNT_W'(WIDTH-1)) || (mplier[WIDTH-1:1] == '0);
`else
  assign run_last = (cnt == CNT_W'(WIDTH-1));
`endif

  assign result = apply_sign(prod, neg);

  // busy is a decode of the state register only, so the stall path has no
  // combinational dependence on start.
  assign busy = (state == S_RUN) || (state == S_FIX);
  assign done = (state == S_FIX) && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        // IDLE: latch magnitudes and sign, or service MTHI/MTLO
        S_IDLE: begin
          if (start && !flush) begin
            mcand  <= {{WIDTH{1'b0}}, magnitude(a, signed_op)};
            mplier <= magnitude(b, signed_op);
            neg    <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
            prod   <= '0;
            cnt    <= '0;
            state  <= S_RUN;
          end else if (!start) begin
            if (mthi) hi <= hi_wdata;
            if (mtlo) lo <= lo_wdata;
          end
        end
        // RUN: one conditional add and one shift per cycle
        S_RUN: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
            mplier <= {1'b0, mplier[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (run_last) state <= S_FIX;
          end
        end
        // FIX: sign-correct the product and commit it to HI/LO
        S_FIX: begin
          state <= S_IDLE;
          if (!flush) begin
            hi <= result[2*WIDTH-1:WIDTH];
            lo <= result[WIDTH-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq.sv
module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, signed_op, flush, mthi, mtlo;
  logic [31:0] a, b, hi_wdata, lo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  mult_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .signed_op(signed_op),
    .flush(flush), .a(a), .b(b), .mthi(mthi), .mtlo(mtlo),
    .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected busy length: WIDTH+1 normally. With early termination it is
  // the index of the top set bit of b plus one (at least one RUN cycle),
  // plus the FIX cycle.
  function automatic int exp_busy(input logic [31:0] bv);
`ifdef MULT_EARLY_TERM_EN
    int n = 0;
    for (int i = 0; i < 32; i++) if (bv[i]) n = i + 1;
    if (n == 0) n = 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  // Load HI/LO through MTHI/MTLO while idle.
  task automatic preset(input logic [31:0] h, input logic [31:0] l);
    mthi = 1'b1; mtlo = 1'b1; hi_wdata = h; lo_wdata = l;
    step();
    mthi = 1'b0; mtlo = 1'b0;
  endtask

  // Issue one multiply and run it to completion. The returned cycle numbers
  // are relative to the start edge T, so cycle 1 is T+1.
  task automatic do_mult(input logic [31:0] av, input logic [31:0] bv,
                         input logic s, output int bcyc, output int dat);
    int k;
    a = av; b = bv; signed_op = s; start = 1'b1;
    step();
    start = 1'b0;
    k = 1; dat = -1;
    while (busy && k <= 100) begin
      if (done) dat = k;
      k++;
      step();
    end
    bcyc = k - 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h required 0/0/0/0",
               busy, done, hi, lo);
    end
    step(); step();
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_multu_basic();
    int k, dat;
    logic held;
    preset(32'hAAAA0000, 32'h0000BBBB);
    a = 32'd3; b = 32'd5; signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    k = 1; dat = -1; held = 1'b1;
    while (busy && k <= 100) begin
      if (done) dat = k;
      if (hi !== 32'hAAAA0000 || lo !== 32'h0000BBBB) held = 1'b0;
      k++;
      step();
    end
    checks++;
    if (k - 1 != exp_busy(32'd5)) begin
      failures++;
      $display("FAIL multu_busy_len: got %0d required %0d", k - 1, exp_busy(32'd5));
    end
    checks++;
    if (dat != exp_busy(32'd5)) begin
      failures++;
      $display("FAIL multu_done_cycle: got %0d required %0d", dat, exp_busy(32'd5));
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL multu_hilo_hold: hi/lo changed before FIX, held=%b required 1", held);
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0000000F) begin
      failures++;
      $display("FAIL multu_3x5: hi=%h lo=%h required 00000000/0000000f", hi, lo);
    end
  endtask

  task automatic test_signed();
    int bc, dat;
    do_mult(32'hFFFFFFFF, 32'd1, 1'b1, bc, dat);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL mult_m1x1: hi=%h lo=%h required ffffffff/ffffffff", hi, lo);
    end
    do_mult(32'h80000000, 32'h80000000, 1'b1, bc, dat);
    checks++;
    if (hi !== 32'h40000000 || lo !== 32'h0) begin
      failures++;
      $display("FAIL mult_minxmin: hi=%h lo=%h required 40000000/00000000", hi, lo);
    end
    do_mult(32'hFFFFFFFD, 32'd5, 1'b1, bc, dat);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFF1) begin
      failures++;
      $display("FAIL mult_m3x5: hi=%h lo=%h required ffffffff/fffffff1", hi, lo);
    end
    do_mult(32'h7FFFFFFF, 32'hFFFFFFFE, 1'b1, bc, dat);
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'h00000002) begin
      failures++;
      $display("FAIL mult_maxxm2: hi=%h lo=%h required ffffffff/00000002", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int k, bc, dat;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    k = 1;
    while (busy && k <= 100) begin
      // a second start mid-run must be ignored
      if (k == 3) begin
        a = 32'd3; b = 32'd5; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      k++;
      step();
    end
    start = 1'b0;
    checks++;
    if (k - 1 != exp_busy(32'hFFFFFFFF)) begin
      failures++;
      $display("FAIL b2b_busy_len: got %0d required %0d", k - 1, exp_busy(32'hFFFFFFFF));
    end
    checks++;
    if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      failures++;
      $display("FAIL multu_maxxmax: hi=%h lo=%h required fffffffe/00000001", hi, lo);
    end
    // immediately issue the next multiply in the first idle cycle
    do_mult(32'd6, 32'd7, 1'b0, bc, dat);
    checks++;
    if (hi !== 32'h0 || lo !== 32'd42) begin
      failures++;
      $display("FAIL b2b_second: hi=%h lo=%h required 00000000/0000002a", hi, lo);
    end
  endtask

  task automatic test_flush();
    logic saw_done;
    preset(32'h00001234, 32'h00005678);
    checks++;
    if (hi !== 32'h00001234 || lo !== 32'h00005678) begin
      failures++;
      $display("FAIL mthi_mtlo_idle: hi=%h lo=%h required 00001234/00005678", hi, lo);
    end
    a = 32'd2;
`ifdef MULT_EARLY_TERM_EN
    b = 32'h80000002;
`else
    b = 32'd2;
`endif
    signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    saw_done = 1'b0;
    // now in cycle T+1; advance to cycle T+10
    for (int i = 0; i < 9; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    flush = 1'b1;
    if (done) saw_done = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_busy: busy=%b at T+11 required 0", busy);
    end
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    checks++;
    if (saw_done !== 1'b0) begin
      failures++;
      $display("FAIL flush_no_done: saw_done=%b required 0", saw_done);
    end
    checks++;
    if (hi !== 32'h00001234 || lo !== 32'h00005678) begin
      failures++;
      $display("FAIL flush_hilo: hi=%h lo=%h required 00001234/00005678", hi, lo);
    end
  endtask

  task automatic test_flush_fix();
    int k;
    preset(32'h0000ABCD, 32'h0000EF01);
    a = 32'd3; b = 32'd5; signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    k = 0;
    while (!done && k < 100) begin
      k++;
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL flush_fix_reach: done=%b required 1 within 100 cycles", done);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0000ABCD || lo !== 32'h0000EF01) begin
      failures++;
      $display("FAIL flush_fix: busy=%b hi=%h lo=%h required 0/0000abcd/0000ef01",
               busy, hi, lo);
    end
  endtask

  task automatic test_flush_start();
    a = 32'd3; b = 32'd5; signed_op = 1'b0; start = 1'b1; flush = 1'b1;
    step();
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_idle: busy=%b required 0", busy);
    end
  endtask

  task automatic test_mthi_busy();
    int k;
    preset(32'h0000AAAA, 32'h0000BBBB);
    a = 32'd1; b = 32'hFFFFFFFF; signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    mthi = 1'b1; mtlo = 1'b1; hi_wdata = 32'hDEADBEEF; lo_wdata = 32'hFEEDFACE;
    step();
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if (hi !== 32'h0000AAAA || lo !== 32'h0000BBBB) begin
      failures++;
      $display("FAIL mthi_busy_ignored: hi=%h lo=%h required 0000aaaa/0000bbbb", hi, lo);
    end
    k = 0;
    while (busy && k < 100) begin
      k++;
      step();
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL mthi_busy_result: hi=%h lo=%h required 00000000/ffffffff", hi, lo);
    end
  endtask

  task automatic test_reset_mid();
    preset(32'h00001111, 32'h00002222);
    a = 32'd3; b = 32'hFFFFFFFF; signed_op = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    // cycle T+5: assert reset asynchronously
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b done=%b hi=%h lo=%h required 0/0/0/0",
               busy, done, hi, lo);
    end
    step();
    rst_n = 1'b1;
    step(); step();
    checks++;
    if (busy !== 1'b0 || hi !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_after: busy=%b hi=%h required 0/00000000", busy, hi);
    end
  endtask

`ifdef MULT_EARLY_TERM_EN
  task automatic test_early_term();
    int bc, dat;
    preset(32'h00000055, 32'h00000066);
    do_mult(32'd7, 32'd0, 1'b0, bc, dat);
    checks++;
    if (bc != 2 || hi !== 32'h0 || lo !== 32'h0) begin
      failures++;
      $display("FAIL early_b0: busy_len=%0d hi=%h lo=%h required 2/0/0", bc, hi, lo);
    end
    do_mult(32'd1, 32'd4, 1'b0, bc, dat);
    checks++;
    if (dat != 4 || lo !== 32'd4 || hi !== 32'h0) begin
      failures++;
      $display("FAIL early_1x4: done_cycle=%0d hi=%h lo=%h required 4/0/4", dat, hi, lo);
    end
  endtask
`endif

  initial begin
    start = 1'b0; signed_op = 1'b0; flush = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    a = '0; b = '0; hi_wdata = '0; lo_wdata = '0;
    test_reset();
    test_multu_basic();
    test_signed();
    test_back_to_back();
    test_flush();
    test_flush_fix();
    test_flush_start();
    test_mthi_busy();
    test_reset_mid();
`ifdef MULT_EARLY_TERM_EN
    test_early_term();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
